// File: rtl/anton_neopixel_pkg.sv
// Shared NeoPixel decoder types: line-state encoding, default WS2812 tick constants at 7MHz.
// Also holds the 24-to-8 bit collapse that undoes the team's 8-bit pixel expansion.
package anton_neopixel_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } neo_state_t;

  localparam int NEO_PIXEL_BITS     = 24;
  localparam int NEO_PIXELS_MAX     = 66;
  localparam int NEO_RESET_DELAY    = 350;
  localparam int NEO_ONE_MIN_TICKS  = 4;
  localparam int NEO_HIGH_MAX_TICKS = 7;

  function automatic logic [7:0] neo_collapse8(input logic [NEO_PIXEL_BITS-1:0] w);
    return {w[17], w[18], w[1], w[2], w[3], w[9], w[10], w[11]};
  endfunction

endpackage

// File: rtl/anton_neopixel_decoder_if.sv
// Pixel output channel of the decoder: valid/ready handshake carrying pixel data and frame index.
// Master (decoder) holds data stable while valid && !ready; pixelData8 exists only with NEO_DECODER_8BIT_EN.
interface anton_neopixel_decoder_if
  import anton_neopixel_pkg::*;
#(
  parameter int PIXELS_MAX = NEO_PIXELS_MAX
);
  localparam int IDX_W = $clog2(PIXELS_MAX);

  logic                      pixelValid;
  logic                      pixelReady;
  logic [NEO_PIXEL_BITS-1:0] pixelData;
  logic [IDX_W-1:0]          pixelIndex;
`ifdef NEO_DECODER_8BIT_EN
  logic [7:0]                pixelData8;

  modport master (output pixelValid, pixelData, pixelIndex, pixelData8, input pixelReady);
  modport slave  (input pixelValid, pixelData, pixelIndex, pixelData8, output pixelReady);
`else
  modport master (output pixelValid, pixelData, pixelIndex, input pixelReady);
  modport slave  (input pixelValid, pixelData, pixelIndex, output pixelReady);
`endif

endinterface

// File: rtl/anton_neopixel_line_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus registered-previous edge detect.
// Latency: 2 cycles to line_sync, edges valid in the same cycle as line_sync; no backpressure.
module anton_neopixel_line_sync (
  input  logic clk7mhz,
  input  logic reset,
  input  logic line_raw,
  output logic line_sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= line_raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_sync = sync_q;
  assign rise      = sync_q & ~prev_q;
  assign fall      = ~sync_q & prev_q;

endmodule

// File: rtl/anton_neopixel_decoder.sv
// WS2812 serial decoder: pulse-width bit decode, 24-bit pixel assembly, frame detect; pixel out one cycle after its last bit.
// One-deep output register; a pixel completing while the previous one is unaccepted is dropped and sets sticky overflow. Optional NEO_DECODER_8BIT_EN adds pixelData8.
module anton_neopixel_decoder
  import anton_neopixel_pkg::*;
#(
  parameter int PIXELS_MAX     = NEO_PIXELS_MAX,
  parameter int RESET_DELAY    = NEO_RESET_DELAY,
  parameter int ONE_MIN_TICKS  = NEO_ONE_MIN_TICKS,
  parameter int HIGH_MAX_TICKS = NEO_HIGH_MAX_TICKS
) (
  input  logic                           clk7mhz,
  input  logic                           reset,
  input  logic                           neoData,
  anton_neopixel_decoder_if.master       pix,
  output logic                           frameDone,
  output logic [$clog2(PIXELS_MAX):0]    frameCount,
  output logic                           errPulse,
  output logic                           overflow
);

  localparam int IDX_W  = $clog2(PIXELS_MAX);
  localparam int PCNT_W = IDX_W + 1;
  localparam int CNT_W  = $clog2(RESET_DELAY + 1);

  localparam logic [CNT_W-1:0]  RST_VAL  = CNT_W'(RESET_DELAY);
  localparam logic [CNT_W-1:0]  ONE_VAL  = CNT_W'(ONE_MIN_TICKS);
  localparam logic [CNT_W-1:0]  HMAX_VAL = CNT_W'(HIGH_MAX_TICKS);
  localparam logic [PCNT_W-1:0] PMAX_VAL = PCNT_W'(PIXELS_MAX);

  logic line_sync;
  logic rise;
  logic fall;

  anton_neopixel_line_sync u_line_sync (
    .clk7mhz   (clk7mhz),
    .reset     (reset),
    .line_raw  (neoData),
    .line_sync (line_sync),
    .rise      (rise),
    .fall      (fall)
  );

  neo_state_t                state_q, state_d;
  logic [CNT_W-1:0]          tick_q, tick_d, tick_inc;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [NEO_PIXEL_BITS-1:0] shreg_q, shreg_d, px_word;
  logic [PCNT_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic                      new_bit;
  logic                      px_done;
  logic                      px_emit;
  logic                      frame_end;
  logic                      err_d;

  assign tick_inc = tick_q + 1'b1;
  assign new_bit  = (tick_q >= ONE_VAL);
  // First wire bit ends up in bit 0 after 24 right shifts.
  assign px_word  = {new_bit, shreg_q[NEO_PIXEL_BITS-1:1]};
  assign px_emit  = px_done && (pix_cnt_q < PMAX_VAL);

  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      state_q   <= ST_RESYNC;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pix_cnt_d = pix_cnt_q;
    px_done   = 1'b0;
    frame_end = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_RESYNC: begin
        if (line_sync) begin
          tick_d = '0;
        end else if (tick_inc == RST_VAL) begin
          state_d   = ST_IDLE;
          tick_d    = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
          pix_cnt_d = '0;
        end else begin
          tick_d = tick_inc;
        end
      end

      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          tick_d  = CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          tick_d  = CNT_W'(1);
          shreg_d = px_word;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            px_done   = 1'b1;
            pix_cnt_d = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (tick_inc == HMAX_VAL) begin
          // Illegal pulse: drop the partial pixel and wait for a full reset gap.
          err_d     = 1'b1;
          state_d   = ST_RESYNC;
          tick_d    = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else begin
          tick_d = tick_inc;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          tick_d  = CNT_W'(1);
        end else if (tick_inc == RST_VAL) begin
          frame_end = 1'b1;
          err_d     = (bit_cnt_q != '0);
          state_d   = ST_IDLE;
          tick_d    = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
          pix_cnt_d = '0;
        end else begin
          tick_d = tick_inc;
        end
      end

      default: begin
        state_d = ST_RESYNC;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      pix.pixelValid <= 1'b0;
      pix.pixelData  <= '0;
      pix.pixelIndex <= '0;
`ifdef NEO_DECODER_8BIT_EN
      pix.pixelData8 <= '0;
`endif
      frameDone      <= 1'b0;
      frameCount     <= '0;
      errPulse       <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      frameDone <= frame_end;
      errPulse  <= err_d;
      if (frame_end) begin
        frameCount <= pix_cnt_q;
      end

      if (pix.pixelValid && pix.pixelReady) begin
        pix.pixelValid <= 1'b0;
      end

      if (px_emit) begin
        if (!pix.pixelValid || pix.pixelReady) begin
          pix.pixelValid <= 1'b1;
          pix.pixelData  <= px_word;
          pix.pixelIndex <= pix_cnt_q[IDX_W-1:0];
`ifdef NEO_DECODER_8BIT_EN
          pix.pixelData8 <= neo_collapse8(px_word);
`endif
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
